// File: rtl/uart_pkg.sv
// ============================================================================
// Package : uart_pkg
// Shared constants, cfg field layout and FSM encoding for the UART RX path.
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OS_RATIO = 16;

  // Tick positions inside a bit period; the vote resolves on the last one.
  localparam logic [3:0] SMP_A    = 4'd7;
  localparam logic [3:0] SMP_B    = 4'd8;
  localparam logic [3:0] SMP_LAST = 4'd9;

  // cfg = {stop_sel, parity_en, parity_even, data_len[1:0]}
  localparam int CFG_LEN   = 0;
  localparam int CFG_PEVEN = 2;
  localparam int CFG_PEN   = 3;
  localparam int CFG_STOP  = 4;

  localparam logic [3:0] LEN_OFFSET = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module : uart_rx_sampler
// Input synchronizer and 3-sample majority voter for the UART receiver.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk16,
  input  logic       rx_sn,
  input  logic [3:0] tc,
  output logic       rxs,
  output logic       bit_val
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_a_q;
  logic                   s_b_q;

  // Flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_sn};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a_q <= 1'b1;
      s_b_q <= 1'b1;
    end else if (clk16) begin
      if (tc == SMP_A) s_a_q <= rxs;
      if (tc == SMP_B) s_b_q <= rxs;
    end
  end

  // Third sample is the live value, valid on the tick where tc == SMP_LAST.
  assign bit_val = (s_a_q & s_b_q) | (s_a_q & rxs) | (s_b_q & rxs);

endmodule

`default_nettype wire

// File: rtl/uart_rx_os16.sv
// ============================================================================
// Module : uart_rx_os16
// 16x-oversampled UART receiver with parity/framing/overrun detection and a
// valid/ready output holding register.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_os16 #(
  parameter int OS_RATIO    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk16,
  input  logic [4:0] cfg,
  input  logic       rx_sn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_par_err,
  output logic       rx_frm_err,
  output logic       rx_ovr_err,
  input  logic       err_clr,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam logic [3:0] TC_WRAP = 4'(OS_RATIO - 1);

  rx_state_e  state_q, state_d;
  logic [3:0] tc_q, tc_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [4:0] cfg_q, cfg_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic       done;
  logic       rxs;
  logic       bit_val;
  logic [3:0] n_bits;
  logic       hold_free;

  logic [7:0] data_q;
  logic       valid_q;
  logic       hpar_q;
  logic       hfrm_q;
  logic       ovr_q;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .clk16   (clk16),
    .rx_sn   (rx_sn),
    .tc      (tc_q),
    .rxs     (rxs),
    .bit_val (bit_val)
  );

  assign n_bits = {2'b00, cfg_q[CFG_LEN +: 2]} + LEN_OFFSET;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tc_q      <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      cfg_q     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tc_q      <= tc_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      cfg_q     <= cfg_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tc_d      = tc_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    cfg_d     = cfg_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done      = 1'b0;
    if (clk16) begin
      tc_d = tc_q + 4'd1;
      case (state_q)
        ST_IDLE: begin
          tc_d = '0;
          if (!rxs) begin
            state_d   = ST_START;
            cfg_d     = cfg;
            bitcnt_d  = '0;
            shreg_d   = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end
        end
        ST_START: begin
          if (tc_q == SMP_LAST && bit_val) begin
            state_d = ST_IDLE;
            tc_d    = '0;
          end else if (tc_q == TC_WRAP) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (tc_q == SMP_LAST) begin
            shreg_d[bitcnt_q[2:0]] = bit_val;
            bitcnt_d               = bitcnt_q + 4'd1;
          end else if (tc_q == TC_WRAP && bitcnt_q == n_bits) begin
            bitcnt_d = '0;
            state_d  = cfg_q[CFG_PEN] ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (tc_q == SMP_LAST) begin
            par_err_d = (^shreg_q) ^ bit_val ^ ~cfg_q[CFG_PEVEN];
          end else if (tc_q == TC_WRAP) begin
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tc_q == SMP_LAST) begin
            if (!bit_val) frm_err_d = 1'b1;
            if (cfg_q[CFG_STOP] && bitcnt_q == 4'd0) begin
              bitcnt_d = 4'd1;
            end else begin
              // Finish mid-bit so the next start edge is caught promptly.
              state_d = ST_IDLE;
              tc_d    = '0;
              done    = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tc_d    = '0;
        end
      endcase
    end
  end

  assign hold_free = !valid_q || rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      hpar_q  <= 1'b0;
      hfrm_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (done && hold_free) begin
        valid_q <= 1'b1;
        data_q  <= shreg_q;
        hpar_q  <= par_err_q;
        hfrm_q  <= frm_err_d;
      end else if (rx_ready) begin
        valid_q <= 1'b0;
      end
      if (done && !hold_free) begin
        ovr_q <= 1'b1;
      end else if (err_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_par_err = hpar_q;
  assign rx_frm_err = hfrm_q;
  assign rx_ovr_err = ovr_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
// ============================================================================
// Module : tb_uart_rx_os16
// Self-checking bench: directed vector table, corner sequences, random frames.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_os16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       clk16    = 1'b0;
  logic [4:0] cfg      = 5'b00011;
  logic       rx_sn    = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clr  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_par_err;
  logic       rx_frm_err;
  logic       rx_ovr_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frm;
  } word_t;
  word_t got_q[$];

  typedef struct {
    logic [4:0] cfg;
    logic [7:0] data;
    logic       par;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_frm;
  } vec_t;
  vec_t vecs[9];

  uart_rx_os16 #(.OS_RATIO(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk16      (clk16),
    .cfg        (cfg),
    .rx_sn      (rx_sn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_par_err (rx_par_err),
    .rx_frm_err (rx_frm_err),
    .rx_ovr_err (rx_ovr_err),
    .err_clr    (err_clr),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (2) @(negedge clk);
    clk16 = 1'b1;
    @(negedge clk);
    clk16 = 1'b0;
  end

  // Delivered words are exactly the handshakes seen on the output port.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      valid_cycles++;
      if (rx_ready) got_q.push_back('{rx_data, rx_par_err, rx_frm_err});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (clk16 !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx_sn = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [4:0] c, input logic [7:0] d, input logic p,
                            input logic s0, input logic s1, input bit scramble);
    int n;
    n   = int'(c[1:0]) + 5;
    cfg = c;
    send_bit(1'b0);
    if (scramble) cfg = 5'($urandom);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (c[3]) send_bit(p);
    send_bit(s0);
    if (c[4]) send_bit(s1);
    rx_sn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (rx_busy && k < 64) begin
      wait_ticks(1);
      k++;
    end
    if (rx_busy) check({name, " busy timeout"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic run_frame(input string name, input logic [4:0] c, input logic [7:0] d,
                           input logic p, input logic s0, input logic s1,
                           input logic [7:0] ed, input logic ep, input logic ef,
                           input bit scramble);
    got_q.delete();
    valid_cycles = 0;
    send_frame(c, d, p, s0, s1, scramble);
    wait_ticks(20);
    wait_idle(name);
    check({name, " words"}, 32'(got_q.size()), 32'd1);
    check({name, " valid_cycles"}, 32'(valid_cycles), 32'd1);
    if (got_q.size() > 0) begin
      check({name, " data"}, 32'(got_q[0].data), 32'(ed));
      check({name, " par"}, 32'(got_q[0].par), 32'(ep));
      check({name, " frm"}, 32'(got_q[0].frm), 32'(ef));
    end
    check({name, " ovr"}, 32'(rx_ovr_err), 32'd0);
  endtask

  initial begin
    logic [4:0] c;
    logic [7:0] d, ed;
    logic       p, s0, s1, ep, ef;
    int         n;

    //           cfg       data   par   s0    s1    exp_d  ep    ef
    vecs[0] = '{5'b00011, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{5'b01110, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[2] = '{5'b01110, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{5'b11000, 8'h15, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1};
    vecs[4] = '{5'b11000, 8'h15, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
    vecs[5] = '{5'b00001, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b0};
    vecs[6] = '{5'b11000, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1};
    vecs[7] = '{5'b01011, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{5'b00011, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    check("reset valid", 32'(rx_valid), 32'd0);
    check("reset data", 32'(rx_data), 32'd0);
    check("reset flags", 32'({rx_par_err, rx_frm_err, rx_ovr_err, rx_busy}), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].data, vecs[i].par,
                vecs[i].s0, vecs[i].s1, vecs[i].exp_data, vecs[i].exp_par,
                vecs[i].exp_frm, 1'b0);
    end

    // Short low pulse must be rejected as a false start.
    valid_cycles = 0;
    rx_sn = 1'b0;
    wait_ticks(4);
    rx_sn = 1'b1;
    wait_ticks(3);
    check("glitch busy during start", 32'(rx_busy), 32'd1);
    wait_ticks(4);
    check("glitch busy after abort", 32'(rx_busy), 32'd0);
    wait_ticks(20);
    check("glitch no valid", 32'(valid_cycles), 32'd0);

    // Overrun: second word arrives while the first is still held.
    rx_ready = 1'b0;
    got_q.delete();
    send_frame(5'b00011, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(5'b00011, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(20);
    wait_idle("ovr");
    check("ovr valid held", 32'(rx_valid), 32'd1);
    check("ovr data kept", 32'(rx_data), 32'h11);
    check("ovr flag", 32'(rx_ovr_err), 32'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("ovr drained words", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("ovr drained data", 32'(got_q[0].data), 32'h11);
    check("ovr valid dropped", 32'(rx_valid), 32'd0);
    check("ovr sticky", 32'(rx_ovr_err), 32'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("ovr cleared", 32'(rx_ovr_err), 32'd0);

    // Asynchronous reset in the middle of a data bit.
    send_frame(5'b00011, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(20);
    check("pre-reset held", 32'(rx_valid), 32'd1);
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx_sn = d[3];
    wait_ticks(8);
    #3 rst = 1'b1;
    #1;
    check("async rst valid", 32'(rx_valid), 32'd0);
    check("async rst data", 32'(rx_data), 32'd0);
    check("async rst busy", 32'(rx_busy), 32'd0);
    check("async rst flags", 32'({rx_par_err, rx_frm_err, rx_ovr_err}), 32'd0);
    rx_sn = 1'b1;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    rx_ready = 1'b1;
    wait_ticks(20);
    run_frame("post-reset", 5'b00011, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Random frames, cfg scrambled after start to confirm it was latched.
    for (int t = 0; t < 25; t++) begin
      c  = 5'($urandom);
      d  = 8'($urandom);
      p  = 1'($urandom);
      s0 = ($urandom_range(0, 5) != 0);
      s1 = ($urandom_range(0, 5) != 0);
      n  = int'(c[1:0]) + 5;
      ed = d & 8'((1 << n) - 1);
      ep = c[3] ? (((($countones(ed) + int'(p)) % 2) != (c[2] ? 0 : 1))) : 1'b0;
      ef = !s0 || (c[4] && !s1);
      run_frame($sformatf("rnd%0d", t), c, d, p, s0, s1, ed, ep, ef, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
